// File: rtl/pueo_beam_pkg.sv
// Shared widths and per-beam state type for the PUEO beam power trigger.
package pueo_beam_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } beamState_t;

  // clog2 that yields 0 for 1, so NINT=1 or NSAMP=1 add no extra bits
  function automatic int clog2z(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  function automatic int beamSumWidth(input int nbits, input int nchan);
    return nbits + 1 + clog2z(nchan);
  endfunction

  function automatic int powerWidth(input int bw, input int nsamp);
    return 2 * bw - 1 + clog2z(nsamp);
  endfunction

  function automatic int windowWidth(input int pw, input int nint);
    return pw + clog2z(nint);
  endfunction

endpackage

// File: rtl/pueo_beam_power.sv
// One beam's power pipeline: channel sum, square, sample sum and a
// running NINT-clock window sum. Four register stages from beam_i to power_o.
module pueo_beam_power
  import pueo_beam_pkg::*;
#(
  parameter int NCHAN = 8,
  parameter int NSAMP = 8,
  parameter int NBITS = 5,
  parameter int NINT  = 2,
  localparam int BW   = beamSumWidth(NBITS, NCHAN),
  localparam int SQW  = 2 * BW - 1,
  localparam int PW   = powerWidth(BW, NSAMP),
  localparam int TW   = windowWidth(PW, NINT)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NCHAN*NSAMP*NBITS-1:0] beam_i,
  output logic [TW-1:0]                power_o
);

  // Offset-binary v maps to 2v - (2^NBITS - 1): symmetric, always odd.
  localparam logic signed [BW-1:0] OFFSET = BW'(2 ** NBITS - 1);

  logic signed [BW-1:0] sumComb [NSAMP];
  logic signed [BW-1:0] sumQ    [NSAMP];
  logic [SQW-1:0]       sqComb  [NSAMP];
  logic [SQW-1:0]       sqQ     [NSAMP];
  logic [PW-1:0]        pComb;
  logic [PW-1:0]        pQ;
  logic [PW-1:0]        histQ   [NINT];
  logic [TW-1:0]        wQ;

  always_comb begin
    for (int s = 0; s < NSAMP; s++) begin
      sumComb[s] = '0;
      for (int c = 0; c < NCHAN; c++) begin
        sumComb[s] = sumComb[s]
                   + $signed(BW'({beam_i[NBITS*(NSAMP*c+s) +: NBITS], 1'b0}))
                   - OFFSET;
      end
    end
  end

  // Squaring in SQW bits is exact: |B| <= (2^NBITS-1)*NCHAN < 2^(BW-1).
  always_comb begin
    for (int s = 0; s < NSAMP; s++) begin
      sqComb[s] = $unsigned(SQW'(sumQ[s]) * SQW'(sumQ[s]));
    end
  end

  always_comb begin
    pComb = '0;
    for (int s = 0; s < NSAMP; s++) begin
      pComb = pComb + PW'(sqQ[s]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < NSAMP; s++) begin
        sumQ[s] <= '0;
        sqQ[s]  <= '0;
      end
      pQ <= '0;
      for (int i = 0; i < NINT; i++) begin
        histQ[i] <= '0;
      end
      wQ <= '0;
    end else begin
      for (int s = 0; s < NSAMP; s++) begin
        sumQ[s] <= sumComb[s];
        sqQ[s]  <= sqComb[s];
      end
      pQ <= pComb;
      // histQ[NINT-1] is the P value sliding out of the window this clock
      wQ <= wQ + TW'(pQ) - TW'(histQ[NINT-1]);
      histQ[0] <= pQ;
      for (int i = 1; i < NINT; i++) begin
        histQ[i] <= histQ[i-1];
      end
    end
  end

  assign power_o = wQ;

endmodule

// File: rtl/pueo_beam_power_trig.sv
// Multi-beam power trigger: per-beam window power vs a double-buffered
// threshold, with per-beam holdoff, masking and a post-reset fill gate.
module pueo_beam_power_trig
  import pueo_beam_pkg::*;
#(
  parameter int NBEAM   = 4,
  parameter int NCHAN   = 8,
  parameter int NSAMP   = 8,
  parameter int NBITS   = 5,
  parameter int NINT    = 2,
  parameter int HOLDOFF = 8,
  localparam int BW     = beamSumWidth(NBITS, NCHAN),
  localparam int PW     = powerWidth(BW, NSAMP),
  localparam int TW     = windowWidth(PW, NINT),
  localparam int SW     = (NBEAM > 1) ? clog2z(NBEAM) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [NBEAM*NCHAN*NSAMP*NBITS-1:0] beam_i,
  input  logic [TW-1:0]                      thresh_i,
  input  logic [SW-1:0]                      thresh_sel_i,
  input  logic                               thresh_wr_i,
  input  logic                               update_i,
  input  logic [NBEAM-1:0]                   beam_mask_i,
  output logic [NBEAM-1:0]                   trigger_o
);

  localparam int BEAMW = NCHAN * NSAMP * NBITS;
  localparam int SELN  = 2 ** SW;
  localparam int HCW   = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  // W first holds NINT real P values after 3+NINT clocks; compare one later.
  localparam int FILL  = 3 + NINT;
  localparam int FCW   = $clog2(FILL + 1);

  logic [TW-1:0] wBeam [NBEAM];

  genvar b;
  generate
    for (b = 0; b < NBEAM; b++) begin : gBeam
      pueo_beam_power #(
        .NCHAN (NCHAN),
        .NSAMP (NSAMP),
        .NBITS (NBITS),
        .NINT  (NINT)
      ) uPower (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .beam_i  (beam_i[b*BEAMW +: BEAMW]),
        .power_o (wBeam[b])
      );
    end
  endgenerate

  // Threshold double buffer: one-hot decode drops out-of-range selects.
  logic [SELN-1:0] selOneHot;
  logic [TW-1:0]   shadowQ [NBEAM];
  logic [TW-1:0]   activeQ [NBEAM];

  assign selOneHot = SELN'(1) << thresh_sel_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NBEAM; i++) begin
        shadowQ[i] <= '1;
        activeQ[i] <= '1;
      end
    end else begin
      for (int i = 0; i < NBEAM; i++) begin
        if (thresh_wr_i && selOneHot[i]) begin
          shadowQ[i] <= thresh_i;
        end
        if (update_i) begin
          activeQ[i] <= shadowQ[i];
        end
      end
    end
  end

  logic [FCW-1:0] fillCnt;
  logic           fillOpen;

  assign fillOpen = (fillCnt == FCW'(FILL));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fillCnt <= '0;
    end else if (!fillOpen) begin
      fillCnt <= fillCnt + 1'b1;
    end
  end

  // Per-beam IDLE/HOLD machine; stateQ and holdCnt are the observable state.
  beamState_t     stateQ      [NBEAM];
  beamState_t     stateNext   [NBEAM];
  logic [HCW-1:0] holdCnt     [NBEAM];
  logic [HCW-1:0] holdCntNext [NBEAM];
  logic [NBEAM-1:0] fire;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NBEAM; i++) begin
        stateQ[i]  <= IDLE;
        holdCnt[i] <= '0;
      end
      trigger_o <= '0;
    end else begin
      for (int i = 0; i < NBEAM; i++) begin
        stateQ[i]  <= stateNext[i];
        holdCnt[i] <= holdCntNext[i];
      end
      trigger_o <= fire;
    end
  end

  always_comb begin
    for (int i = 0; i < NBEAM; i++) begin
      stateNext[i]   = stateQ[i];
      holdCntNext[i] = '0;
      if (beam_mask_i[i]) begin
        stateNext[i] = IDLE;
      end else begin
        case (stateQ[i])
          IDLE: begin
            if (fire[i]) begin
              stateNext[i] = HOLD;
            end
          end
          HOLD: begin
            if (holdCnt[i] == HCW'(HOLDOFF - 1)) begin
              stateNext[i] = IDLE;
            end else begin
              holdCntNext[i] = holdCnt[i] + 1'b1;
            end
          end
          default: stateNext[i] = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBEAM; i++) begin
      fire[i] = (stateQ[i] == IDLE) && !beam_mask_i[i] && fillOpen
              && (wBeam[i] > activeQ[i]);
    end
  end

endmodule

// File: tb/tb_pueo_beam_power_trig.sv
// Bench for pueo_beam_power_trig: directed scenarios plus random traffic,
// checked every cycle against a window-power / holdoff model.
module tb_pueo_beam_power_trig;

  localparam int NBEAM   = 4;
  localparam int NCHAN   = 8;
  localparam int NSAMP   = 8;
  localparam int NBITS   = 5;
  localparam int NINT    = 2;
  localparam int HOLDOFF = 8;
  localparam int BEAMW   = NCHAN * NSAMP * NBITS;
  // BW = 5+1+3 = 9, PW = 17+3 = 20, TW = 20+1 = 21
  localparam int TW      = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NBEAM*BEAMW-1:0] beam_in = '0;
  logic [TW-1:0]          thresh_in = '0;
  logic [1:0]             thresh_sel = '0;
  logic                   thresh_wr = 1'b0;
  logic                   update = 1'b0;
  logic [NBEAM-1:0]       beam_mask = '0;
  logic [NBEAM-1:0]       trig;

  pueo_beam_power_trig #(
    .NBEAM(NBEAM), .NCHAN(NCHAN), .NSAMP(NSAMP), .NBITS(NBITS),
    .NINT(NINT), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .beam_i       (beam_in),
    .thresh_i     (thresh_in),
    .thresh_sel_i (thresh_sel),
    .thresh_wr_i  (thresh_wr),
    .update_i     (update),
    .beam_mask_i  (beam_mask),
    .trigger_o    (trig)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint calc_p(input logic [NBEAM*BEAMW-1:0] bv, input int b);
    longint p = 0;
    for (int s = 0; s < NSAMP; s++) begin
      longint sum = 0;
      for (int c = 0; c < NCHAN; c++) begin
        int v = int'(bv[b*BEAMW + NBITS*(NSAMP*c+s) +: NBITS]);
        sum += 2 * v - (2 ** NBITS - 1);
      end
      p += sum * sum;
    end
    return p;
  endfunction

  logic [NBEAM-1:0] exp_q[$];
  int               edge_cnt;
  longint           p_hist [NBEAM][64];
  int               last_fire [NBEAM];
  logic [TW-1:0]    shadow_m [NBEAM];
  logic [TW-1:0]    active_m [NBEAM];

  // Edge k compares the window of inputs captured at edges k-4-NINT+1 .. k-4.
  initial begin
    logic [NBEAM-1:0] ev;
    longint w;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_cnt = 0;
        exp_q.delete();
        for (int b = 0; b < NBEAM; b++) begin
          last_fire[b] = -1000;
          shadow_m[b]  = '1;
          active_m[b]  = '1;
          for (int e = 0; e < 64; e++) p_hist[b][e] = 0;
        end
      end else begin
        edge_cnt++;
        ev = '0;
        for (int b = 0; b < NBEAM; b++) begin
          p_hist[b][edge_cnt % 64] = calc_p(beam_in, b);
          w = 0;
          for (int j = 0; j < NINT; j++) begin
            if (edge_cnt - 4 - j >= 1) w += p_hist[b][(edge_cnt - 4 - j) % 64];
          end
          if (beam_mask[b]) begin
            last_fire[b] = -1000;
          end else if (edge_cnt >= 4 + NINT && edge_cnt - last_fire[b] > HOLDOFF
                       && w > longint'(active_m[b])) begin
            ev[b] = 1'b1;
            last_fire[b] = edge_cnt;
          end
        end
        exp_q.push_back(ev);
        if (update) for (int b = 0; b < NBEAM; b++) active_m[b] = shadow_m[b];
        if (thresh_wr) shadow_m[thresh_sel] = thresh_in;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    logic [NBEAM-1:0] ev;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        check("trigger_vs_model", 32'(trig), 32'(ev));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_beam(input int b, input int v);
    for (int c = 0; c < NCHAN; c++)
      for (int s = 0; s < NSAMP; s++)
        beam_in[b*BEAMW + NBITS*(NSAMP*c+s) +: NBITS] = NBITS'(v);
  endtask

  task automatic set_all(input int v);
    for (int b = 0; b < NBEAM; b++) set_beam(b, v);
  endtask

  // channels alternate s=+1 / s=-1, so every beam sum is zero
  task automatic set_alt(input int b);
    for (int c = 0; c < NCHAN; c++)
      for (int s = 0; s < NSAMP; s++)
        beam_in[b*BEAMW + NBITS*(NSAMP*c+s) +: NBITS] = (c % 2 == 0) ? 5'd16 : 5'd15;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    thresh_wr = 1'b0;
    update = 1'b0;
    beam_mask = '0;
    repeat (3) @(negedge clk);
    check("reset_trigger", 32'(trig), 32'd0);
    check("reset_w0", 32'(dut.wBeam[0]), 32'd0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic write_thresh(input int sel, input int v);
    thresh_sel = 2'(sel);
    thresh_in  = TW'(v);
    thresh_wr  = 1'b1;
    tick();
    thresh_wr  = 1'b0;
  endtask

  task automatic do_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic load_all(input int v);
    for (int b = 0; b < NBEAM; b++) write_thresh(b, v);
    do_update();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int pulses;
    int pulse_cyc;

    // s=+1 everywhere: W=1024 > 1023, pulses at 6 then every HOLDOFF+1
    set_all(16);
    do_reset();
    load_all(1023);
    check("prefill_quiet", 32'(trig), 32'd0);
    tick();
    check("first_pulse_c6", 32'(trig), 32'hf);
    check("w_1024", 32'(dut.wBeam[0]), 32'd1024);
    while (cyc < 14) tick();
    check("holdoff_gap_c14", 32'(trig), 32'd0);
    tick();
    check("second_pulse_c15", 32'(trig), 32'hf);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_trig", 32'(trig), 32'd0);
    check("async_reset_w", 32'(dut.wBeam[2]), 32'd0);

    // strict compare: W == threshold never fires
    set_all(16);
    do_reset();
    load_all(1024);
    pulses = 0;
    repeat (30) begin
      tick();
      if (trig != 0) pulses++;
    end
    check("strict_no_pulse", 32'(pulses), 32'd0);

    // full-scale beam 0, zero-sum beams 1-3
    set_beam(0, 31);
    for (int b = 1; b < NBEAM; b++) set_alt(b);
    do_reset();
    write_thresh(0, 984063);
    for (int b = 1; b < NBEAM; b++) write_thresh(b, 0);
    do_update();
    tick();
    check("fullscale_pulse", 32'(trig), 32'b0001);
    check("w0_fullscale", 32'(dut.wBeam[0]), 32'd984064);
    check("w1_zero", 32'(dut.wBeam[1]), 32'd0);
    check("w3_zero", 32'(dut.wBeam[3]), 32'd0);
    repeat (12) tick();

    // one-cycle burst at cyc 10 -> single pulse at cyc 15
    for (int b = 0; b < NBEAM; b++) set_alt(b);
    do_reset();
    load_all(511);
    while (cyc < 10) tick();
    set_all(16);
    tick();
    for (int b = 0; b < NBEAM; b++) set_alt(b);
    pulses = 0;
    pulse_cyc = -1;
    while (cyc < 30) begin
      tick();
      if (trig != 0) begin
        pulses++;
        pulse_cyc = cyc;
      end
    end
    check("burst_count", 32'(pulses), 32'd1);
    check("burst_cycle", 32'(pulse_cyc), 32'd15);

    // write and update together: update takes the pre-write shadow
    set_all(16);
    do_reset();
    write_thresh(0, 2000);
    do_update();
    while (cyc < 10) tick();
    thresh_sel = 2'd0;
    thresh_in  = TW'(100);
    thresh_wr  = 1'b1;
    update     = 1'b1;
    tick();
    thresh_wr = 1'b0;
    update    = 1'b0;
    pulses = 0;
    while (cyc < 20) begin
      tick();
      if (trig[0]) pulses++;
    end
    check("coincident_old_thresh", 32'(pulses), 32'd0);
    do_update();
    check("update_not_yet", 32'(trig[0]), 32'd0);
    tick();
    check("new_thresh_fires", 32'(trig[0]), 32'd1);
    repeat (5) tick();

    // mask during HOLD clears it; beam 0 fires as soon as it is released
    set_all(16);
    do_reset();
    load_all(1023);
    while (cyc < 8) tick();
    beam_mask = 4'b0001;
    pulses = 0;
    while (cyc < 11) begin
      tick();
      if (trig[0]) pulses++;
    end
    check("masked_quiet", 32'(pulses), 32'd0);
    beam_mask = '0;
    tick();
    check("mask_release_fires", 32'(trig), 32'b0001);
    repeat (12) tick();

    // random traffic with a mid-run reset
    for (int b = 0; b < NBEAM; b++)
      for (int i = 0; i < NCHAN * NSAMP; i++)
        beam_in[b*BEAMW + i*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      for (int b = 0; b < NBEAM; b++) write_thresh(b, $urandom_range(30000, 60000));
      do_update();
      for (int n = 0; n < 200; n++) begin
        for (int b = 0; b < NBEAM; b++)
          for (int i = 0; i < NCHAN * NSAMP; i++)
            beam_in[b*BEAMW + i*NBITS +: NBITS] = NBITS'($urandom_range(0, 31));
        for (int b = 0; b < NBEAM; b++) beam_mask[b] = ($urandom_range(0, 15) == 0);
        thresh_wr  = ($urandom_range(0, 3) == 0);
        thresh_sel = 2'($urandom_range(0, 3));
        thresh_in  = TW'($urandom_range(30000, 60000));
        update     = ($urandom_range(0, 7) == 0);
        tick();
      end
      thresh_wr = 1'b0;
      update    = 1'b0;
      beam_mask = '0;
      #7 rst_n = 1'b0;
      #1;
      check("random_async_reset", 32'(trig), 32'd0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
